// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and active-low SRAM strobe values for the boot loader
package boot_pkg;
  typedef enum logic [2:0] {LOAD, CHECK, RELEASE, RUN, ERROR} boot_state_t;
  localparam int SRAM_DATA_W = 32;
  localparam logic CSB_ON  = 1'b0;
  localparam logic CSB_OFF = 1'b1;
  localparam logic WEB_WR  = 1'b0;
  localparam logic WEB_RD  = 1'b1;
endpackage

// File: rtl/boot_checksum.sv
// boot_checksum: mod-2^32 running sum of image words with compare against a trailing sum word
module boot_checksum
  import boot_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   add,
  input  logic [SRAM_DATA_W-1:0] data,
  input  logic [SRAM_DATA_W-1:0] cmp_data,
  output logic                   match
);
  logic [SRAM_DATA_W-1:0] sum_q, sum_d;
  always_comb sum_d = add ? (clr ? data : sum_q + data) : sum_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) sum_q <= '0;
    else sum_q <= sum_d;
  assign match = sum_q == cmp_data;
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program image into the instruction SRAM, then releases the core
// Optional BOOT_CHECKSUM_EN: consume and verify a trailing checksum word before release.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int ADDR_W        = $clog2(DEPTH),
  parameter int RELEASE_DELAY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  input  logic [SRAM_DATA_W-1:0] load_data,
  output logic                   load_ready,
  input  logic [ADDR_W-1:0]      core_addr,
  output logic                   core_reset,
  output logic                   load_done,
  output logic                   load_err,
  output logic                   sram_csb,
  output logic                   sram_web,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_din
);
  localparam int RC_W = $clog2(RELEASE_DELAY + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(RELEASE_DELAY);
  boot_state_t state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d, addr_q, addr_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic [SRAM_DATA_W-1:0] din_q, din_d;
  logic csb_q, csb_d, web_q, web_d, core_reset_q, core_reset_d, done_q, done_d;
  logic accept;
  assign load_ready = state_q == LOAD || state_q == CHECK;
  assign accept = load_valid & load_ready;
`ifdef BOOT_CHECKSUM_EN
  logic err_q, err_d, sum_match;
  boot_checksum u_sum (
    .clk      (clk),
    .reset    (reset),
    .clr      (wcnt_q == '0),
    .add      (state_q == LOAD && accept),
    .data     (load_data),
    .cmp_data (load_data),
    .match    (sum_match)
  );
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    csb_d        = CSB_OFF;
    web_d        = WEB_RD;
    addr_d       = addr_q;
    din_d        = din_q;
    core_reset_d = core_reset_q;
    done_d       = done_q;
`ifdef BOOT_CHECKSUM_EN
    err_d        = err_q;
`endif
    case (state_q)
      LOAD: if (accept) begin
        csb_d  = CSB_ON;
        web_d  = WEB_WR;
        addr_d = wcnt_q;
        din_d  = load_data;
        wcnt_d = wcnt_q == LAST ? wcnt_q : wcnt_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
        if (wcnt_q == LAST) state_d = CHECK;
`else
        if (wcnt_q == LAST) begin
          state_d = RELEASE;
          rcnt_d  = RC_INIT;
        end
`endif
      end
`ifdef BOOT_CHECKSUM_EN
      CHECK: if (accept) begin
        state_d = sum_match ? RELEASE : ERROR;
        rcnt_d  = RC_INIT;
        err_d   = !sum_match;
      end
`endif
      RELEASE: if (rcnt_q == '0) begin
        state_d      = RUN;
        core_reset_d = 1'b0;
        done_d       = 1'b1;
        csb_d        = CSB_ON;
      end else rcnt_d = rcnt_q - 1'b1;
      RUN: csb_d = CSB_ON;
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= LOAD;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      csb_q        <= CSB_OFF;
      web_q        <= WEB_RD;
      addr_q       <= '0;
      din_q        <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      csb_q        <= csb_d;
      web_q        <= web_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
`ifdef BOOT_CHECKSUM_EN
      err_q        <= err_d;
`endif
    end
  // in RUN the core PC drives the SRAM address directly so fetch adds no latency
  assign sram_addr  = state_q == RUN ? core_addr : addr_q;
  assign sram_csb   = csb_q;
  assign sram_web   = web_q;
  assign sram_din   = din_q;
  assign core_reset = core_reset_q;
  assign load_done  = done_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized image loads checked against an array model of the SRAM image
module tb_imem_boot_loader;
  localparam int DEPTH = 64;
  localparam int ADDR_W = 6;
  localparam int RD = 2;
`ifdef BOOT_CHECKSUM_EN
  localparam int NW = DEPTH + 1;
`else
  localparam int NW = DEPTH;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic [ADDR_W-1:0] core_addr = '0;
  logic load_ready, core_reset, load_done, load_err, sram_csb, sram_web;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0] sram_din;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_wr_edge = 0;
  int last_acc_edge = 0;
  int wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] img[DEPTH];
  imem_boot_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .core_addr  (core_addr),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din)
  );
  always #5 clk = ~clk;
  // the SRAM captures a write at the edge where registered csb/web are both low
  always @(posedge clk) begin
    cyc++;
    if (!sram_csb && !sram_web) begin
      wr_addr.push_back(int'(sram_addr));
      wr_data.push_back(sram_din);
      last_wr_edge = cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] img_sum();
    logic [31:0] s = '0;
    for (int i = 0; i < DEPTH; i++) s += img[i];
    return s;
  endfunction
  task automatic rand_img();
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    load_valid = 1'b0;
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_csb", sram_csb, 1);
    chk("rst_web", sram_web, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_din", sram_din, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask
  task automatic run_load(input bit gap, input int n_words, input logic [31:0] sum_adj);
    int k = 0;
    int t = 0;
    int bad = 0;
    logic prev_wr = 1'b0;
    logic [31:0] sum_word = img_sum() + sum_adj;
    while (k < n_words && t < 2000) begin
      @(negedge clk);
      if (t > 0) bad += int'(sram_csb !== !prev_wr || sram_web !== !prev_wr);
      load_valid = gap ? (t % 3 == 0) : 1'b1;
      load_data = !load_valid ? $urandom : (k < DEPTH ? img[k] : sum_word);
      prev_wr = load_valid && load_ready && k < DEPTH;
      if (load_valid && load_ready) begin
        k++;
        last_acc_edge = cyc + 1;
      end
      t++;
    end
    @(negedge clk);
    bad += int'(sram_csb !== !prev_wr || sram_web !== !prev_wr);
    load_valid = 1'b0;
    chk("idle_csb_web", bad, 0);
    chk("load_accepts", k, n_words);
  endtask
  task automatic wait_release(output int drop_edge);
    int t = 0;
    while (core_reset === 1'b1 && load_err !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    drop_edge = cyc;
  endtask
  task automatic verify_writes(input string tag);
    chk({tag, "_wr_count"}, wr_addr.size(), DEPTH);
    for (int i = 0; i < wr_addr.size() && i < DEPTH; i++) begin
      chk({tag, "_wr_addr"}, wr_addr[i], i);
      chk({tag, "_wr_data"}, wr_data[i], img[i]);
    end
  endtask
  task automatic check_run(input string tag);
    chk({tag, "_core_reset"}, core_reset, 0);
    chk({tag, "_load_done"}, load_done, 1);
    chk({tag, "_load_err"}, load_err, 0);
  endtask
  initial begin
    int e, n;
    for (int i = 0; i < DEPTH; i++) img[i] = i * 4 + 1;
    do_reset();
    run_load(1'b0, NW, 0);
    wait_release(e);
    chk("t1_release_delay", e - last_acc_edge, RD + 1);
`ifndef BOOT_CHECKSUM_EN
    chk("t1_wr_to_release", e - last_wr_edge, RD);
`endif
    check_run("t1");
    verify_writes("t1");
    n = wr_addr.size();
    core_addr = 5;
    #1;
    chk("t3_addr5", sram_addr, 5);
    chk("t3_web", sram_web, 1);
    chk("t3_csb", sram_csb, 0);
    chk("t3_ready", load_ready, 0);
    core_addr = 63;
    #1;
    chk("t3_addr63", sram_addr, 63);
    repeat (8) begin
      @(negedge clk);
      load_valid = 1'($urandom);
      load_data = $urandom;
      core_addr = ADDR_W'($urandom);
      #1;
      chk("t3_addr_follow", sram_addr, core_addr);
    end
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_no_write", wr_addr.size(), n);
    check_run("t3");
    rand_img();
    do_reset();
    run_load(1'b1, NW, 0);
    wait_release(e);
    check_run("t2");
    verify_writes("t2");
    rand_img();
    do_reset();
    run_load(1'b0, 10, 0);
    @(negedge clk);
    chk("t4_partial_writes", wr_addr.size(), 10);
    do_reset();
    rand_img();
    run_load(1'b0, NW, 0);
    wait_release(e);
    check_run("t4");
    verify_writes("t4");
`ifdef BOOT_CHECKSUM_EN
    rand_img();
    do_reset();
    run_load(1'b1, NW, 0);
    wait_release(e);
    check_run("t5");
    verify_writes("t5");
    rand_img();
    do_reset();
    run_load(1'b0, NW, 1);
    wait_release(e);
    repeat (20) begin
      @(negedge clk);
      load_valid = 1'($urandom);
      load_data = $urandom;
    end
    load_valid = 1'b0;
    @(negedge clk);
    chk("t6_load_err", load_err, 1);
    chk("t6_core_reset", core_reset, 1);
    chk("t6_load_done", load_done, 0);
    chk("t6_ready", load_ready, 0);
    chk("t6_csb", sram_csb, 1);
    verify_writes("t6");
`else
    chk("err_tied_low", load_err, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
